mac_array_3x3: RTL and testbench
================================

# mac_array_3x3

Nine-cell multiply-accumulate array that sits directly downstream of the matrix memory bank. Each cycle it consumes one column of W (three elements) and one row of X (three elements) and accumulates the outer-product terms into a 3x3 grid of result registers, gated per cell by the bank's load and clear strobes. When the bank signals that multiplication is complete, the block drains the valid part of the result grid in row-major order over a valid/ready stream.

## Interface
- DATA_W, 4, width of each input matrix element (unsigned)
- ACC_W, 10, accumulator and result width (unsigned)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- data_outw1/2/3  input  DATA_W  W column elements for rows 0/1/2
- data_outx1/2/3  input  DATA_W  X row elements for columns 0/1/2
- ld_mac  input  9  per-cell accumulate enable; bit 3*i+j is cell (i,j)
- clear_mac  input  9  per-cell clear; same bit mapping
- unload_res  input  1  multiplication complete; level signal
- row_w  input  2  result rows (0..3)
- col_x  input  2  result columns (0..3)
- res_data  output  ACC_W  result element
- res_idx  output  4  cell index 3*i+j of res_data
- res_valid  output  1  res_data/res_idx/res_last valid
- res_ready  input  1  downstream accepts beat
- res_last  output  1  final beat of the drain
- mac_done  output  1  one-cycle pulse after final beat accepted

## Operation
- Cell (i,j) update priority: rst > clear_mac[k] > freeze (state not IDLE) > ld_mac[k] (acc += w_i * x_j) > hold.
- Product: DATA_W x DATA_W -> 2*DATA_W bits unsigned, zero-extended to ACC_W; sum wraps modulo 2^ACC_W (3x3 with DATA_W=4 max 675, never wraps).
- FSM states: IDLE, DRAIN, DONE.
  - IDLE: accumulate. unload_res sampled high -> latch row_w, col_x into rows_q, cols_q; clear r=c=0; go to DRAIN. If latched rows or cols is 0 -> go straight to DONE with mac_done pulse, no beats.
  - DRAIN: res_valid=1, res_data=acc[r][c], res_idx=3*r+c, res_last=(r==rows_q-1 && c==cols_q-1). On valid&ready: advance c; at c==cols_q-1 wrap c=0, r++. Beat with res_last accepted -> DONE.
  - DONE: res_valid=0; mac_done high on first DONE cycle only. unload_res sampled low -> IDLE.
- Accumulators are frozen in DRAIN and DONE (ld_mac ignored; clear_mac still honoured in DONE only, ignored in DRAIN so output stays stable).
- Outputs are registered; res_data/res_idx/res_last are held stable while res_valid=1 and res_ready=0.

## Timing
- Reset values: all accumulators 0, state IDLE, res_valid 0, res_last 0, res_data 0, res_idx 0, mac_done 0.
- Accumulate latency: inputs at edge N appear in acc after edge N.
- unload_res high at edge N -> first res_valid high in cycle after N.
- Drain of R x C beats with res_ready tied high: R*C cycles; res_last on beat R*C; mac_done high the cycle after.
- res_ready low stalls indefinitely with no beat lost or duplicated.
- unload_res dropping during DRAIN is ignored; drain completes.
- rst mid-drain: next cycle IDLE, res_valid 0, accumulators 0.
- ld_mac and clear_mac both set for a cell: cell clears.

## Test plan
- 2x2: W=[[1,2],[3,4]], X=[[5,6],[7,8]]; feed (w=1,3,0 / x=5,6,0) then (2,4,0 / 7,8,0), ld_mac=9'b000011011; unload_res, row_w=col_x=2, ready=1 -> beats idx 0,1,3,4 = 19,22,43,50, res_last on 50, mac_done next cycle.
- 3x3 all elements 15, three feed cycles, ld_mac all ones -> nine beats each 675, idx 0..8 in order.
- Backpressure on 2x2 case: res_ready toggles 1,0,0,1,0,1,1 -> exactly four beats 19,22,43,50, data stable during stalls.
- row_w=0 with unload_res -> no res_valid, mac_done pulse one cycle after sampling.
- rst asserted during second beat of 3x3 drain -> res_valid 0 next cycle, all accumulators read 0 on a following 1x1 job with zero inputs.
- clear_mac[4] with ld_mac[4] in same cycle after accumulating 43 -> cell 4 reads 0; other cells unchanged.

Source files
------------

// File: rtl/mac_array_3x3.sv
// 3x3 outer-product multiply-accumulate grid fed by the matrix memory bank.
// Result cells are drained row-major over a valid/ready stream once multiplication completes.
module mac_array_3x3 #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_outw1,
  input  logic [DATA_W-1:0] data_outw2,
  input  logic [DATA_W-1:0] data_outw3,
  input  logic [DATA_W-1:0] data_outx1,
  input  logic [DATA_W-1:0] data_outx2,
  input  logic [DATA_W-1:0] data_outx3,
  input  logic [8:0]        ld_mac,
  input  logic [8:0]        clear_mac,
  input  logic              unload_res,
  input  logic [1:0]        row_w,
  input  logic [1:0]        col_x,
  output logic [ACC_W-1:0]  res_data,
  output logic [3:0]        res_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              mac_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]   w_el [3];
  logic [DATA_W-1:0]   x_el [3];
  logic [2*DATA_W-1:0] prod [9];
  logic [ACC_W-1:0]    acc_q [9];
  logic [ACC_W-1:0]    acc_d [9];

  logic [1:0]       r_q, c_q, r_d, c_d;
  logic [1:0]       rows_q, cols_q, rows_d, cols_d;
  logic [1:0]       nr, nc;
  logic             valid_d, last_d, done_d;
  logic [ACC_W-1:0] data_d;
  logic [3:0]       idx_d;

  assign w_el[0] = data_outw1;
  assign w_el[1] = data_outw2;
  assign w_el[2] = data_outw3;
  assign x_el[0] = data_outx1;
  assign x_el[1] = data_outx2;
  assign x_el[2] = data_outx3;

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return {2'b00, r} * 4'd3 + {2'b00, c};
  endfunction

  always_comb begin : outer_product
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        prod[3*i+j] = w_el[i] * x_el[j];
  end

  // Clear wins over load; draining freezes the grid so the beat on the bus cannot change.
  always_comb begin : acc_next
    for (int k = 0; k < 9; k++) begin
      acc_d[k] = acc_q[k];
      if (clear_mac[k] && state_q != DRAIN)
        acc_d[k] = '0;
      else if (ld_mac[k] && state_q == IDLE)
        acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
    end
  end

  // NOTE: the accumulator array is reset explicitly because a rst mid-job must leave every cell at 0.
  always_ff @(posedge clk) begin : acc_reg
    for (int k = 0; k < 9; k++) begin
      if (rst) acc_q[k] <= '0;
      else     acc_q[k] <= acc_d[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin : state_reg
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (unload_res) state_d = (row_w == 2'd0 || col_x == 2'd0) ? DONE : DRAIN;
      DRAIN:   if (res_ready && res_last) state_d = DONE;
      DONE:    if (!unload_res) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin : output_next
    r_d     = r_q;
    c_d     = c_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    nr      = r_q;
    nc      = c_q;
    valid_d = res_valid;
    data_d  = res_data;
    idx_d   = res_idx;
    last_d  = res_last;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (unload_res) begin
          rows_d = row_w;
          cols_d = col_x;
          r_d    = 2'd0;
          c_d    = 2'd0;
          if (state_d == DRAIN) begin
            valid_d = 1'b1;
            idx_d   = 4'd0;
            data_d  = acc_d[0];
            last_d  = (row_w == 2'd1) && (col_x == 2'd1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (res_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (c_q == cols_q - 2'd1) begin
              nc = 2'd0;
              nr = r_q + 2'd1;
            end else begin
              nc = c_q + 2'd1;
            end
            r_d    = nr;
            c_d    = nc;
            idx_d  = cell_idx(nr, nc);
            data_d = acc_d[idx_d];
            last_d = (nr == rows_q - 2'd1) && (nc == cols_q - 2'd1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : output_reg
    if (rst) begin
      r_q       <= '0;
      c_q       <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
      mac_done  <= 1'b0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      res_valid <= valid_d;
      res_data  <= data_d;
      res_idx   <= idx_d;
      res_last  <= last_d;
      mac_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_mac_array_3x3.sv
// Self-checking bench for mac_array_3x3: directed cases plus randomized jobs
// compared against an array-of-integers model of the accumulator grid.
module tb_mac_array_3x3;
  localparam int DATA_W = 4;
  localparam int ACC_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_outw1, data_outw2, data_outw3;
  logic [DATA_W-1:0] data_outx1, data_outx2, data_outx3;
  logic [8:0]        ld_mac, clear_mac;
  logic              unload_res;
  logic [1:0]        row_w, col_x;
  logic [ACC_W-1:0]  res_data;
  logic [3:0]        res_idx;
  logic              res_valid, res_ready, res_last, mac_done;

  always #5 clk = ~clk;

  mac_array_3x3 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .data_outw1(data_outw1), .data_outw2(data_outw2), .data_outw3(data_outw3),
    .data_outx1(data_outx1), .data_outx2(data_outx2), .data_outx3(data_outx3),
    .ld_mac(ld_mac), .clear_mac(clear_mac), .unload_res(unload_res),
    .row_w(row_w), .col_x(col_x),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
    .res_ready(res_ready), .res_last(res_last), .mac_done(mac_done)
  );

  int checks = 0;
  int errors = 0;
  int model [9];
  int seen_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) model[k] = 0;
  endtask

  // One accumulate cycle in IDLE: outer product of w and x into the masked cells.
  task automatic feed(input int w0, input int w1, input int w2,
                      input int x0, input int x1, input int x2,
                      input logic [8:0] ld, input logic [8:0] clr);
    int w [3];
    int x [3];
    w = '{w0, w1, w2};
    x = '{x0, x1, x2};
    data_outw1 = 4'(w0); data_outw2 = 4'(w1); data_outw3 = 4'(w2);
    data_outx1 = 4'(x0); data_outx2 = 4'(x1); data_outx3 = 4'(x2);
    ld_mac = ld;
    clear_mac = clr;
    for (int k = 0; k < 9; k++) begin
      if (clr[k])     model[k] = 0;
      else if (ld[k]) model[k] = (model[k] + w[k/3] * x[k%3]) % 1024;
    end
    tick();
    ld_mac = '0;
    clear_mac = '0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: fixed 1,0,0,1,0,1,1 pattern
  task automatic drain(input int rows, input int cols, input int mode, input bit drop_unload);
    int  exp_data [$];
    int  exp_idx [$];
    int  cyc;
    bit  last_seen;
    bit  abort;
    bit  rdy;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp_data.push_back(model[3*r+c]);
        exp_idx.push_back(3*r+c);
      end
    seen_q.delete();
    row_w = 2'(rows);
    col_x = 2'(cols);
    unload_res = 1'b1;
    tick();
    if (drop_unload) unload_res = 1'b0;
    if (exp_data.size() == 0) begin
      check("empty_valid", res_valid, 0);
      check("empty_done", mac_done, 1);
      tick();
      check("empty_done_pulse", mac_done, 0);
      check("empty_valid_after", res_valid, 0);
    end else begin
      check("first_valid", res_valid, 1);
      cyc = 0;
      last_seen = 1'b0;
      abort = 1'b0;
      while (!last_seen && !abort && cyc < 200) begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (cyc < 7) ? pat[cyc] : 1'b1;
        endcase
        res_ready = rdy;
        check("drain_done_low", mac_done, 0);
        if (!res_valid) begin
          check("drain_valid", res_valid, 1);
          abort = 1'b1;
        end else begin
          check("beat_data", res_data, exp_data[0]);
          check("beat_idx", res_idx, exp_idx[0]);
          check("beat_last", res_last, exp_data.size() == 1);
          if (rdy) begin
            seen_q.push_back(int'(res_data));
            last_seen = (exp_data.size() == 1);
            void'(exp_data.pop_front());
            void'(exp_idx.pop_front());
          end
        end
        cyc++;
        tick();
      end
      res_ready = 1'b0;
      check("drain_complete", last_seen, 1);
      if (mode == 0) check("drain_cycles", cyc, rows * cols);
      check("mac_done", mac_done, 1);
      check("valid_after_last", res_valid, 0);
      tick();
      check("done_pulse_width", mac_done, 0);
      check("valid_in_done", res_valid, 0);
    end
    unload_res = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {data_outw1, data_outw2, data_outw3} = '0;
    {data_outx1, data_outx2, data_outx3} = '0;
    ld_mac = '0;
    clear_mac = '0;
    unload_res = 1'b0;
    row_w = '0;
    col_x = '0;
    res_ready = 1'b0;
    model_clear();
    tick();
    tick();
    check("rst_valid", res_valid, 0);
    check("rst_last", res_last, 0);
    check("rst_data", res_data, 0);
    check("rst_idx", res_idx, 0);
    check("rst_done", mac_done, 0);
    rst = 1'b0;
    tick();

    // 2x2 product, then the same drain under backpressure
    feed(1, 3, 0, 5, 6, 0, 9'b000011011, 9'b0);
    feed(2, 4, 0, 7, 8, 0, 9'b000011011, 9'b0);
    drain(2, 2, 0, 1'b0);
    check("mm2_beats", seen_q.size(), 4);
    if (seen_q.size() == 4) begin
      check("mm2_b0", seen_q[0], 19);
      check("mm2_b1", seen_q[1], 22);
      check("mm2_b2", seen_q[2], 43);
      check("mm2_b3", seen_q[3], 50);
    end
    drain(2, 2, 2, 1'b0);
    check("bp_beats", seen_q.size(), 4);
    if (seen_q.size() == 4) check("bp_b3", seen_q[3], 50);

    // full 3x3 of 15s, unload_res dropped mid-drain
    feed(0, 0, 0, 0, 0, 0, 9'b0, 9'h1FF);
    for (int n = 0; n < 3; n++) feed(15, 15, 15, 15, 15, 15, 9'h1FF, 9'b0);
    drain(3, 3, 0, 1'b1);
    check("full_beats", seen_q.size(), 9);
    foreach (seen_q[i]) check("full_val", seen_q[i], 675);

    // empty jobs
    drain(0, 2, 0, 1'b0);
    drain(3, 0, 0, 1'b0);

    // reset during the second beat of a 3x3 drain
    row_w = 2'd3;
    col_x = 2'd3;
    unload_res = 1'b1;
    tick();
    res_ready = 1'b1;
    check("rst_drain_b0", res_data, 675);
    tick();
    check("rst_drain_b1_idx", res_idx, 1);
    check("rst_drain_b1_valid", res_valid, 1);
    unload_res = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b0;
    model_clear();
    check("rst_drain_valid", res_valid, 0);
    check("rst_drain_done", mac_done, 0);
    feed(0, 0, 0, 0, 0, 0, 9'h1FF, 9'b0);
    drain(1, 1, 0, 1'b0);
    check("post_rst_1x1", seen_q.size() == 1 ? seen_q[0] : -1, 0);
    drain(3, 3, 1, 1'b0);

    // clear and load on the same cell: clear wins, neighbours keep accumulating
    feed(0, 6, 0, 0, 7, 0, 9'h1FF, 9'b0);
    feed(0, 1, 0, 0, 1, 0, 9'h1FF, 9'b0);
    feed(3, 5, 7, 2, 4, 6, 9'h1FF, 9'h010);
    drain(3, 3, 1, 1'b0);
    check("clr_ld_cell4", seen_q.size() == 9 ? seen_q[4] : -1, 0);

    // randomized jobs
    for (int t = 0; t < 25; t++) begin
      int nfeed;
      nfeed = $urandom_range(1, 4);
      for (int f = 0; f < nfeed; f++)
        feed($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             9'($urandom), ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'b0);
      drain($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
